memory_writeback_cycle: RTL and testbench
=========================================

# memory_writeback_cycle

Memory-access and MEM/WB pipeline stage of the 5-stage RISC-V core. It accepts the EX/MEM-registered instruction fields and performs loads and stores over a req/ack data-memory handshake with variable latency. While an access is outstanding it stalls the upstream pipeline. It then produces the writeback triple (RegWriteW, RDW, ResultW) that drives the decode stage's register-file write port.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: max cycles mem_req may stay high without mem_ack before abort; legal range 1..255.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- ValidM  in  1  EX/MEM slot holds a real instruction.
- RegWriteM  in  1  instruction writes rd.
- MemWriteM  in  1  store.
- ResultSrcM  in  1  1 = load (result from memory), 0 = ALU result.
- RDM  in  5  destination register.
- ALUResultM  in  32  ALU result; also the memory byte address.
- WriteDataM  in  32  store data.
- mem_req  out  1  access request; held until mem_ack or abort.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req.
- mem_addr  out  32  equals ALUResultM.
- mem_wdata  out  32  equals WriteDataM.
- mem_ack  in  1  completes the access in the same cycle; mem_rdata valid with it for reads.
- mem_rdata  in  32  read data.
- StallM  out  1  freeze PC, IF/ID, ID/EX and EX/MEM this cycle.
- RegWriteW  out  1  register-file write enable.
- RDW  out  5  write address.
- ResultW  out  32  write data.
- BusErrW  out  1  sticky: a memory access timed out.

## Operation
- mem_op = ValidM & (MemWriteM | ResultSrcM). MemWriteM and ResultSrcM never both set; if both are set, treat the instruction as a store.
- FSM states:
  - IDLE → ACCESS when mem_op & ~mem_ack.
  - ACCESS → IDLE on mem_ack, or on abort (wait counter == TIMEOUT_CYCLES-1 with no ack).
  - IDLE stays IDLE on a zero-wait access (ack in the same cycle).
- mem_req = rst & ((IDLE & mem_op) | ACCESS); combinational, so a zero-wait access completes without a stall.
- mem_we = MemWriteM. mem_addr and mem_wdata are combinational passthroughs. They are stable during ACCESS because EX/MEM is frozen by StallM.
- StallM = mem_req & ~mem_ack & ~abort. In the abort cycle StallM = 0 and mem_req = 1 (the last request cycle).
- Wait counter (8-bit):
  - Cleared in IDLE.
  - Increments each ACCESS cycle without ack.
  - Never wraps, because abort occurs first.
- MEM/WB register, updated each posedge:
  - When StallM = 1: RegWriteW <= 0 (bubble); RDW and ResultW hold.
  - When StallM = 0: RegWriteW <= ValidM & RegWriteM & ~abort & (RDM != 0). RDW <= RDM. ResultW <= (ResultSrcM & mem_ack) ? mem_rdata : ALUResultM.
  - A store never writes the register file, since RegWriteM = 0 for stores.
  - An aborted load writes nothing; ResultW takes ALUResultM.
- BusErrW: set on the abort cycle's posedge and held until reset.

## Timing
- Reset values: state IDLE, counter 0, RegWriteW 0, RDW 0, ResultW 0, BusErrW 0. mem_req and StallM are 0 while rst = 0, regardless of inputs.
- Reset asserted mid-access: mem_req drops asynchronously, the outstanding access is abandoned, and no writeback occurs.
- Non-memory instruction: W outputs valid 1 cycle after the EX/MEM slot; no stall.
- Memory op acked k cycles after first request (k = 0 means same cycle):
  - StallM high for exactly k cycles.
  - k bubbles (RegWriteW = 0) enter W.
  - Result appears in W at posedge k+1.
- Timeout: mem_req high exactly TIMEOUT_CYCLES cycles. StallM high TIMEOUT_CYCLES-1 cycles. Then one bubble with RegWriteW = 0, and BusErrW = 1 from that edge.
- Back-to-back memory ops: the next op's request may start in the cycle after an ack, with no idle gap required.
- mem_ack while mem_req = 0: ignored.

## Test plan
- Reset: drive rst=0 mid-load in ACCESS → mem_req, StallM, RegWriteW, RDW, ResultW, BusErrW all 0 immediately; after release with ValidM=0, state stays IDLE.
- ALU op: ValidM=1, RegWriteM=1, RDM=5, ALUResultM=0x00001234 → next edge RegWriteW=1, RDW=5, ResultW=0x00001234; StallM never 1; mem_req 0.
- Load, ack 3 cycles late, mem_rdata=0xDEADBEEF, RDM=7, ALUResultM=0x100:
  - mem_req=1, mem_we=0, mem_addr=0x100 for 4 cycles.
  - StallM=1 for 3 cycles, with RegWriteW=0 on those edges.
  - Then RegWriteW=1, RDW=7, ResultW=0xDEADBEEF.
- Zero-wait store: MemWriteM=1, ALUResultM=0x200, WriteDataM=0xCAFEF00D, ack same cycle → mem_we=1 with that addr/data for one cycle; StallM=0; RegWriteW=0.
- Timeout, TIMEOUT_CYCLES=4, load with no ack → mem_req=1 for exactly 4 cycles, StallM=1 for 3; RegWriteW=0; BusErrW=1 and stays 1 through subsequent ALU ops until reset.
- Load to x0 acked with 0x55 → RegWriteW=0; a following load to x3 acked in 1 cycle still completes normally.

Source files
------------

// File: rtl/memory_writeback_cycle_if.sv
// Data-memory request/acknowledge bus between the MEM stage and data memory.
interface memory_writeback_cycle_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // The pipeline stage issues requests; memory answers with ack/rdata.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/memory_writeback_cycle.sv
// MEM stage plus MEM/WB register of the 5-stage RISC-V core. Loads and
// stores go out over a variable-latency req/ack bus; the upstream pipeline
// is stalled while an access waits, and a stuck access is aborted after
// TIMEOUT_CYCLES request cycles with a sticky bus-error flag.
module memory_writeback_cycle #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ValidM,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RDM,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  memory_writeback_cycle_if.master bus,
  output logic        StallM,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        BusErrW
);

  typedef enum logic [0:0] {IDLE, ACCESS} state_t;

  // Wait-count value seen in the last permitted request cycle.
  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [7:0]  wait_cnt;
  logic        mem_op;
  logic        req;
  logic        ack_ok;
  logic        abort;
  logic        is_load;

  assign mem_op  = ValidM & (MemWriteM | ResultSrcM);
  // A store wins if both MemWriteM and ResultSrcM are set.
  assign is_load = ResultSrcM & ~MemWriteM;

  assign bus.mem_req   = req;
  assign bus.mem_we    = MemWriteM;
  assign bus.mem_addr  = ALUResultM;
  assign bus.mem_wdata = WriteDataM;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:   if (mem_op && !bus.mem_ack && !abort) state_next = ACCESS;
      ACCESS: if (bus.mem_ack || abort)             state_next = IDLE;
      default:                                      state_next = IDLE;
    endcase
  end

  // Output logic: request, abort detection and upstream stall.
  always_comb begin
    req    = rst & (((state == IDLE) & mem_op) | (state == ACCESS));
    ack_ok = req & bus.mem_ack;
    // wait_cnt is 0 in the first (IDLE) request cycle, so the request stays
    // up for exactly TIMEOUT_CYCLES cycles before the abort cycle ends it.
    abort  = req & ~bus.mem_ack & (wait_cnt == LAST_WAIT);
    StallM = req & ~bus.mem_ack & ~abort;
  end

  // Wait counter: counts request cycles without ack, cleared otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        wait_cnt <= 8'd0;
    else if (StallM) wait_cnt <= wait_cnt + 8'd1;
    else             wait_cnt <= 8'd0;
  end

  // MEM/WB register: bubble while stalled, otherwise capture the result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW <= 1'b0;
      RDW       <= 5'd0;
      ResultW   <= 32'd0;
    end else if (StallM) begin
      RegWriteW <= 1'b0;
    end else begin
      RegWriteW <= ValidM & RegWriteM & ~abort & (RDM != 5'd0);
      RDW       <= RDM;
      ResultW   <= (is_load & ack_ok) ? bus.mem_rdata : ALUResultM;
    end
  end

  // Sticky bus error, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       BusErrW <= 1'b0;
    else if (abort) BusErrW <= 1'b1;
  end

endmodule

// File: tb/tb_memory_writeback_cycle.sv
// Directed bench for memory_writeback_cycle: a table of single-cycle
// vectors plus hand-written multi-cycle sequences (wait states, timeout,
// back-to-back ops, reset mid-access).
module tb_memory_writeback_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidM, RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RDM;
  logic [31:0] ALUResultM, WriteDataM;
  logic        StallM, RegWriteW, BusErrW;
  logic [4:0]  RDW;
  logic [31:0] ResultW;

  int n_checks = 0;
  int n_fail   = 0;

  memory_writeback_cycle_if bus ();

  memory_writeback_cycle #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .MemWriteM  (MemWriteM),
    .ResultSrcM (ResultSrcM),
    .RDM        (RDM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .bus        (bus.master),
    .StallM     (StallM),
    .RegWriteW  (RegWriteW),
    .RDW        (RDW),
    .ResultW    (ResultW),
    .BusErrW    (BusErrW)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, mw, rs;
    logic [4:0]  rd;
    logic [31:0] alu, wd;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req, exp_we, exp_stall, exp_rw;
    logic [4:0]  exp_rd;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_in(input logic valid, input logic rw, input logic mw, input logic rs,
                        input logic [4:0] rd, input logic [31:0] alu, input logic [31:0] wd,
                        input logic ack, input logic [31:0] rdata);
    ValidM = valid; RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs;
    RDM = rd; ALUResultM = alu; WriteDataM = wd;
    bus.mem_ack = ack; bus.mem_rdata = rdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    //            valid rw mw rs rd  alu           wd            ack rdata         req we st rw rd  res
    vecs[0] = '{1, 1, 0, 0, 5'd5,  32'h0000_1234, 32'h0,        0, 32'h0,         0, 0, 0, 1, 5'd5,  32'h0000_1234};
    vecs[1] = '{1, 0, 0, 0, 5'd9,  32'h0000_AAAA, 32'h0,        0, 32'h0,         0, 0, 0, 0, 5'd9,  32'h0000_AAAA};
    vecs[2] = '{0, 1, 0, 0, 5'd4,  32'h0000_0077, 32'h0,        0, 32'h0,         0, 0, 0, 0, 5'd4,  32'h0000_0077};
    vecs[3] = '{1, 0, 1, 0, 5'd0,  32'h0000_0200, 32'hCAFE_F00D, 1, 32'h0,        1, 1, 0, 0, 5'd0,  32'h0000_0200};
    vecs[4] = '{1, 1, 0, 1, 5'd6,  32'h0000_0300, 32'h0,        1, 32'h1234_5678, 1, 0, 0, 1, 5'd6,  32'h1234_5678};
    vecs[5] = '{1, 1, 0, 1, 5'd0,  32'h0000_0304, 32'h0,        1, 32'h0000_0055, 1, 0, 0, 0, 5'd0,  32'h0000_0055};
    vecs[6] = '{0, 1, 0, 1, 5'd8,  32'h0000_0044, 32'h0,        1, 32'hFFFF_0000, 0, 0, 0, 0, 5'd8,  32'h0000_0044};
    vecs[7] = '{1, 1, 0, 0, 5'd31, 32'hFFFF_FFFF, 32'h0,        0, 32'h0,         0, 0, 0, 1, 5'd31, 32'hFFFF_FFFF};
    vecs[8] = '{1, 0, 1, 1, 5'd2,  32'h0000_0400, 32'h1111_2222, 1, 32'h0000_0099, 1, 1, 0, 0, 5'd2,  32'h0000_0400};

    // Reset state.
    rst = 1'b0;
    set_in(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    #2;
    check("reset mem_req", 32'(bus.mem_req), 32'd0);
    check("reset StallM", 32'(StallM), 32'd0);
    check("reset RegWriteW", 32'(RegWriteW), 32'd0);
    check("reset RDW", 32'(RDW), 32'd0);
    check("reset ResultW", ResultW, 32'd0);
    check("reset BusErrW", 32'(BusErrW), 32'd0);
    #10 rst = 1'b1;

    // Single-cycle vectors.
    foreach (vecs[i]) begin
      set_in(vecs[i].valid, vecs[i].rw, vecs[i].mw, vecs[i].rs, vecs[i].rd,
             vecs[i].alu, vecs[i].wd, vecs[i].ack, vecs[i].rdata);
      #1;
      check($sformatf("vec%0d mem_req", i), 32'(bus.mem_req), 32'(vecs[i].exp_req));
      check($sformatf("vec%0d StallM", i), 32'(StallM), 32'(vecs[i].exp_stall));
      if (vecs[i].exp_req) begin
        check($sformatf("vec%0d mem_we", i), 32'(bus.mem_we), 32'(vecs[i].exp_we));
        check($sformatf("vec%0d mem_addr", i), bus.mem_addr, vecs[i].alu);
        check($sformatf("vec%0d mem_wdata", i), bus.mem_wdata, vecs[i].wd);
      end
      step();
      check($sformatf("vec%0d RegWriteW", i), 32'(RegWriteW), 32'(vecs[i].exp_rw));
      check($sformatf("vec%0d RDW", i), 32'(RDW), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d ResultW", i), ResultW, vecs[i].exp_res);
    end
    check("no bus error yet", 32'(BusErrW), 32'd0);

    // Load acked 3 cycles late; W holds the previous (vec8) entry meanwhile.
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 1, 5'd7, 32'h0000_0100, 32'h0, (i == 3), 32'hDEAD_BEEF);
      #1;
      check($sformatf("k3 c%0d mem_req", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("k3 c%0d mem_we", i), 32'(bus.mem_we), 32'd0);
      check($sformatf("k3 c%0d mem_addr", i), bus.mem_addr, 32'h0000_0100);
      check($sformatf("k3 c%0d StallM", i), 32'(StallM), 32'(i < 3));
      step();
      check($sformatf("k3 e%0d RegWriteW", i), 32'(RegWriteW), 32'(i == 3));
      check($sformatf("k3 e%0d RDW", i), 32'(RDW), (i == 3) ? 32'd7 : 32'd2);
      check($sformatf("k3 e%0d ResultW", i), ResultW, (i == 3) ? 32'hDEAD_BEEF : 32'h0000_0400);
    end

    // Back-to-back load to x3, acked after one wait cycle.
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 1, 5'd3, 32'h0000_0108, 32'h0, (i == 1), 32'h0BAD_F00D);
      #1;
      check($sformatf("x3 c%0d mem_req", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("x3 c%0d StallM", i), 32'(StallM), 32'(i == 0));
      step();
      check($sformatf("x3 e%0d RegWriteW", i), 32'(RegWriteW), 32'(i == 1));
    end
    check("x3 RDW", 32'(RDW), 32'd3);
    check("x3 ResultW", ResultW, 32'h0BAD_F00D);

    // Timeout: load never acked, TIMEOUT_CYCLES = 4.
    for (int i = 0; i < 4; i++) begin
      set_in(1, 1, 0, 1, 5'd12, 32'h0000_0500, 32'h0, 0, 32'h0);
      #1;
      check($sformatf("to c%0d mem_req", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("to c%0d StallM", i), 32'(StallM), 32'(i < 3));
      step();
      check($sformatf("to e%0d RegWriteW", i), 32'(RegWriteW), 32'd0);
      check($sformatf("to e%0d BusErrW", i), 32'(BusErrW), 32'(i == 3));
    end
    check("to aborted ResultW", ResultW, 32'h0000_0500);

    // ALU ops after the abort: request gone, bus error stays set.
    for (int i = 0; i < 2; i++) begin
      set_in(1, 1, 0, 0, 5'(20 + i), 32'(32'h600 + i), 32'h0, 0, 32'h0);
      #1;
      check($sformatf("post-to c%0d mem_req", i), 32'(bus.mem_req), 32'd0);
      step();
      check($sformatf("post-to e%0d RegWriteW", i), 32'(RegWriteW), 32'd1);
      check($sformatf("post-to e%0d ResultW", i), ResultW, 32'(32'h600 + i));
      check($sformatf("post-to e%0d BusErrW", i), 32'(BusErrW), 32'd1);
    end

    // Reset asserted while a load sits in ACCESS.
    set_in(1, 1, 0, 1, 5'd10, 32'h0000_0700, 32'h0, 0, 32'h0);
    step();
    check("rst-mid ACCESS StallM", 32'(StallM), 32'd1);
    #3 rst = 1'b0;
    #1;
    check("rst-mid mem_req", 32'(bus.mem_req), 32'd0);
    check("rst-mid StallM", 32'(StallM), 32'd0);
    check("rst-mid RegWriteW", 32'(RegWriteW), 32'd0);
    check("rst-mid RDW", 32'(RDW), 32'd0);
    check("rst-mid ResultW", ResultW, 32'd0);
    check("rst-mid BusErrW", 32'(BusErrW), 32'd0);
    step();
    check("rst-held RegWriteW", 32'(RegWriteW), 32'd0);
    set_in(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);
    rst = 1'b1;
    step();
    check("post-rst idle mem_req", 32'(bus.mem_req), 32'd0);
    check("post-rst idle StallM", 32'(StallM), 32'd0);
    set_in(1, 1, 0, 0, 5'd1, 32'h0000_0ABC, 32'h0, 0, 32'h0);
    #1;
    check("post-rst ALU mem_req", 32'(bus.mem_req), 32'd0);
    step();
    check("post-rst ALU RegWriteW", 32'(RegWriteW), 32'd1);
    check("post-rst ALU ResultW", ResultW, 32'h0000_0ABC);
    check("post-rst BusErrW", 32'(BusErrW), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
